// File: rtl/loop_pkg.sv
// loop_pkg: shared state encoding and default index width for the nested loop sequencer
package loop_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int IW_DEFAULT = 4;
endpackage

// File: rtl/loop_counter.sv
// loop_counter: wrap-at-bound counter; ports clk, rst (async active-low), clr, en, bound, cnt, carry
module loop_counter #(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [IW-1:0] bound,
    output logic [IW-1:0] cnt,
    output logic          carry
);
    logic [IW-1:0] r_cnt;
    assign cnt   = r_cnt;
    assign carry = en && (r_cnt == bound - IW'(1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en) r_cnt <= carry ? '0 : r_cnt + IW'(1);
    end
endmodule

// File: rtl/nested_loop_sequencer.sv
// nested_loop_sequencer: emits (i,j) pairs j-innermost over valid/ready, done pulse at end.
//   in : clk, rst (async active-low), start, abort, n_outer, n_inner, idx_ready
//   out: idx_i, idx_j, idx_last, idx_valid, busy, done
//   LOOP_LINEAR_IDX_EN adds lin_idx = i*n_inner+j, kept as a running handshake count
module nested_loop_sequencer
    import loop_pkg::*;
#(
    parameter int IW = IW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [IW-1:0] n_outer,
    input  logic [IW-1:0] n_inner,
    output logic [IW-1:0] idx_i,
    output logic [IW-1:0] idx_j,
    output logic          idx_last,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic          busy,
    output logic          done
`ifdef LOOP_LINEAR_IDX_EN
    ,output logic [2*IW-1:0] lin_idx
`endif
);
    state_t        r_state, w_next;
    logic [IW-1:0] r_n_outer, r_n_inner;
    logic          w_accept, w_hs, w_clr, w_inner_carry, w_outer_carry;

    assign idx_valid = (r_state == RUN);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign idx_last  = idx_valid && (idx_i == r_n_outer - IW'(1)) && (idx_j == r_n_inner - IW'(1));
    assign w_accept  = (r_state == IDLE) && start && !abort;
    assign w_hs      = idx_valid && idx_ready;
    assign w_clr     = w_accept || abort;

    loop_counter #(.IW(IW)) u_inner (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_hs),
        .bound(r_n_inner), .cnt(idx_j), .carry(w_inner_carry)
    );

    // outer advances only on the inner wrap; both wrap to 0 after the last pair
    loop_counter #(.IW(IW)) u_outer (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_inner_carry),
        .bound(r_n_outer), .cnt(idx_i), .carry(w_outer_carry)
    );

    always_comb begin
        w_next = r_state;
        if (abort) w_next = IDLE;
        else if (r_state == IDLE) w_next = start ? ((n_outer == '0 || n_inner == '0) ? DONE : RUN) : IDLE;
        else if (r_state == RUN) w_next = (w_hs && idx_last) ? DONE : RUN;
        else w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_n_outer <= '0;
            r_n_inner <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_n_outer <= n_outer;
                r_n_inner <= n_inner;
            end
        end
    end

`ifdef LOOP_LINEAR_IDX_EN
    logic [2*IW-1:0] r_lin;
    assign lin_idx = r_lin;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_lin <= '0;
        else if (w_accept) r_lin <= '0;
        else if (w_hs) r_lin <= r_lin + (2*IW)'(1);
    end
`endif
endmodule

// File: tb/tb_nested_loop_sequencer.sv
// tb_nested_loop_sequencer: randomized directed bench against a queue-based pair model
module tb_nested_loop_sequencer;
    logic       clk = 0;
    logic       rst = 0;
    logic       start = 0, abort = 0, idx_ready = 0;
    logic [3:0] n_outer = 0, n_inner = 0;
    logic [3:0] idx_i, idx_j;
    logic       idx_last, idx_valid, busy, done;
`ifdef LOOP_LINEAR_IDX_EN
    logic [7:0] lin_idx;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nested_loop_sequencer #(.IW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_outer(n_outer), .n_inner(n_inner),
        .idx_i(idx_i), .idx_j(idx_j), .idx_last(idx_last), .idx_valid(idx_valid),
        .idx_ready(idx_ready), .busy(busy), .done(done)
`ifdef LOOP_LINEAR_IDX_EN
        , .lin_idx(lin_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(idx_valid), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".last"}, 32'(idx_last), 0);
    endtask

    // Expected pairs come from plain nested loops; one is consumed per observed handshake.
    task automatic run(input int no, input int ni, input bit rnd_ready, input bit noise);
        int q_i[$];
        int q_j[$];
        int cyc = 0;
        for (int i = 0; i < no; i++)
            for (int j = 0; j < ni; j++) begin
                q_i.push_back(i);
                q_j.push_back(j);
            end
        start = 1; n_outer = 4'(no); n_inner = 4'(ni);
        @(posedge clk); #1;
        start = 0;
        if (noise) begin
            n_outer = 4'($urandom);
            n_inner = 4'($urandom);
        end
        while (q_i.size() > 0 && cyc < 2000) begin
            idx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("run.valid", 32'(idx_valid), 1);
            chk("run.busy", 32'(busy), 1);
            chk("run.i", 32'(idx_i), 32'(q_i[0]));
            chk("run.j", 32'(idx_j), 32'(q_j[0]));
            chk("run.last", 32'(idx_last), 32'(q_i.size() == 1));
            chk("run.done", 32'(done), 0);
`ifdef LOOP_LINEAR_IDX_EN
            chk("run.lin", 32'(lin_idx), 32'(q_i[0] * ni + q_j[0]));
`endif
            if (idx_ready) begin
                void'(q_i.pop_front());
                void'(q_j.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("run.timeout", 32'(q_i.size()), 0);
        start = 0;
        idx_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("end.done", 32'(done), 1);
        chk("end.valid", 32'(idx_valid), 0);
        chk("end.busy", 32'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("end.idle");
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk_idle("reset");
        chk("reset.i", 32'(idx_i), 0);
        chk("reset.j", 32'(idx_j), 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        run(2, 3, 0, 0);
        run(0, 5, 0, 0);
        run(4, 0, 1, 0);
        run(2, 2, 1, 0);
        run(3, 4, 1, 1);
        run(15, 15, 0, 1);
        run(15, 1, 1, 0);
        run(1, 15, 1, 0);
        for (int k = 0; k < 6; k++) run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1, 1);

        // abort after the third handshake of a 3x3 run
        start = 1; n_outer = 3; n_inner = 3; idx_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort.j", 32'(idx_j), 32'(k));
            @(posedge clk); #1;
        end
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle("abort.after");
            @(posedge clk); #1;
        end
        run(1, 1, 0, 0);

        // abort and start together in IDLE: start dropped
        start = 1; abort = 1; n_outer = 2; n_inner = 2;
        @(posedge clk); #1;
        start = 0; abort = 0;
        @(negedge clk);
        chk_idle("abort_start");
        @(posedge clk); #1;

        // async reset between edges mid-run
        start = 1; n_outer = 3; n_inner = 3; idx_ready = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #3;
        rst = 0;
        #1;
        chk_idle("async_rst");
        chk("async_rst.i", 32'(idx_i), 0);
        chk("async_rst.j", 32'(idx_j), 0);
        start = 1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold.busy", 32'(busy), 0);
            chk("rst_hold.valid", 32'(idx_valid), 0);
        end
        start = 0;
        #2 rst = 1;
        @(posedge clk); #1;
        run(2, 3, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
